zx81_tape_saver: RTL and testbench

- Decodes the ZX81/ZX80 SAVE pulse stream (the MIC level driven by the vsync port toggling) back into bytes.
- Stores the captured program in an internal 16 KB buffer, which the HPS upload path reads out as a .p/.o image.
- Sits beside the tape loader as the write-direction counterpart, and taps the core's momentary vsync/MIC level.

---
 rtl/zx81_tape_saver_if.sv | 27 ++
 rtl/zx81_tape_saver.sv | 171 +++++++++++++++++
 tb/tb_zx81_tape_saver.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/zx81_tape_saver_if.sv
// Control, status and upload-read signals of the ZX81 tape saver.
// The host side (master) drives the controls and reads the buffer.
interface zx81_tape_saver_if #(
  parameter int ADDR_W = 14
);
  logic              ce_tick;
  logic              arm;
  logic              skip_name;
  logic              mic;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [ADDR_W:0]   byte_count;
  logic              busy;
  logic              done;
  logic              overflow;
  logic              pulse_err;

  modport master (
    output ce_tick, arm, skip_name, mic, rd_addr,
    input  rd_data, byte_count, busy, done, overflow, pulse_err
  );

  modport slave (
    input  ce_tick, arm, skip_name, mic, rd_addr,
    output rd_data, byte_count, busy, done, overflow, pulse_err
  );
endinterface

// File: rtl/zx81_tape_saver.sv
// Decodes the ZX81/ZX80 SAVE pulse stream on MIC into bytes and stores them
// in an internal buffer that the upload path reads back as a .p/.o image.
module zx81_tape_saver #(
  parameter int TICK_HZ    = 3250000,
  parameter int MIN_TICKS  = 65,
  parameter int GAP_TICKS  = 2600,
  parameter int END_TICKS  = 1625000,
  parameter int ONE_THRESH = 6,
  parameter int ADDR_W     = 14
) (
  input logic              clk_sys,
  input logic              reset,
  zx81_tape_saver_if.slave bus
);

  localparam int GW = $clog2(END_TICKS + 1);
  localparam logic [GW-1:0]   MIN_C   = GW'(MIN_TICKS);
  localparam logic [GW-1:0]   GAP_M1  = GW'(GAP_TICKS - 1);
  localparam logic [GW-1:0]   END_C   = GW'(END_TICKS);
  localparam logic [GW-1:0]   END_M1  = GW'(END_TICKS - 1);
  localparam logic [GW-1:0]   GAP_ONE = GW'(1);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  // Bit end and recording end are told apart only by the gap length.
  if (END_TICKS <= GAP_TICKS || GAP_TICKS <= MIN_TICKS || TICK_HZ <= 0) begin : g_param_check
    $error("zx81_tape_saver: inconsistent tick thresholds");
  end

  typedef enum logic [1:0] {IDLE, NAME, DATA, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        mic_sync_q;
  logic [GW-1:0]     gap_q, gap_d;
  logic [3:0]        pulse_q, pulse_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shreg_q, shreg_d;
  logic              seen_q, seen_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              perr_q, perr_d;
  logic [7:0]        rd_data_q;
  logic [7:0]        mem_q [2**ADDR_W];

  logic              rise;
  logic              capturing;
  logic              edge_acc;
  logic              bit_end;
  logic              end_hit;
  logic              bit_val;
  logic              byte_done;
  logic [7:0]        byte_val;
  logic              wr_en;

  assign rise      = mic_sync_q[1] & ~mic_sync_q[2];
  assign capturing = (state_q == NAME) || (state_q == DATA);
  assign edge_acc  = capturing && rise && ((gap_q >= MIN_C) || (pulse_q == 4'd0));
  assign bit_end   = capturing && !edge_acc && bus.ce_tick && (gap_q == GAP_M1) && (pulse_q != 4'd0);
  // The ROM leader is long silence, so the timeout only counts once pulses have been seen.
  assign end_hit   = capturing && !edge_acc && bus.ce_tick && (gap_q == END_M1) && seen_q;
  assign bit_val   = (pulse_q >= 4'(ONE_THRESH));
  assign byte_val  = {shreg_q, bit_val};
  assign byte_done = bit_end && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    pulse_d   = pulse_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    seen_d    = seen_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    perr_d    = perr_q;
    wr_en     = 1'b0;

    if (edge_acc) begin
      gap_d = '0;
    end else if (bus.ce_tick && (gap_q != END_C)) begin
      gap_d = gap_q + GAP_ONE;
    end

    if (bus.arm) begin
      state_d   = bus.skip_name ? NAME : DATA;
      pulse_d   = '0;
      bit_cnt_d = '0;
      shreg_d   = '0;
      seen_d    = 1'b0;
      count_d   = '0;
      ovf_d     = 1'b0;
      perr_d    = 1'b0;
    end else if (capturing) begin
      if (edge_acc) begin
        seen_d = 1'b1;
        if (pulse_q == 4'd15) begin
          perr_d = 1'b1;
        end else begin
          pulse_d = pulse_q + 4'd1;
        end
      end
      if (bit_end) begin
        pulse_d   = '0;
        shreg_d   = {shreg_q[5:0], bit_val};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (byte_done) begin
        if (state_q == NAME) begin
          if (byte_val[7]) begin
            state_d = DATA;
          end
        end else if (count_q[ADDR_W]) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CNT_ONE;
        end
      end
      if (end_hit) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      mic_sync_q <= '0;
      gap_q      <= '0;
      pulse_q    <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      seen_q     <= 1'b0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mic_sync_q <= {mic_sync_q[1:0], bus.mic};
      gap_q      <= gap_d;
      pulse_q    <= pulse_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      seen_q     <= seen_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      perr_q     <= perr_d;
    end
  end

  // Same-address read during a write returns the previous contents.
  always_ff @(posedge clk_sys) begin
    if (wr_en) begin
      mem_q[count_q[ADDR_W-1:0]] <= byte_val;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[bus.rd_addr];
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.byte_count = count_q;
  assign bus.busy       = capturing;
  assign bus.done       = (state_q == DONE);
  assign bus.overflow   = ovf_q;
  assign bus.pulse_err  = perr_q;

endmodule

// File: tb/tb_zx81_tape_saver.sv
// Scoreboard bench for zx81_tape_saver with scaled-down tick thresholds so whole
// recordings, including a buffer overflow, fit in a short run.
module tb_zx81_tape_saver;

  localparam int AW    = 4;
  localparam int MIN_T = 6;
  localparam int GAP_T = 20;
  localparam int END_T = 200;
  localparam int ONE_T = 6;

  typedef struct {
    int count;
    bit ovf;
    bit perr;
    int nBytes;
  } exp_t;

  exp_t       expQ[$];
  int         expAddrQ[$];
  logic [7:0] expDataQ[$];

  int total = 0;
  int bad   = 0;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;

  always #5 clk_sys = ~clk_sys;

  zx81_tape_saver_if #(.ADDR_W(AW)) busIf();

  zx81_tape_saver #(
    .TICK_HZ   (100000000),
    .MIN_TICKS (MIN_T),
    .GAP_TICKS (GAP_T),
    .END_TICKS (END_T),
    .ONE_THRESH(ONE_T),
    .ADDR_W    (AW)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (busIf)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic pushExp(input int count, input bit ovf, input bit perr, input int nBytes);
    exp_t rec;
    rec.count  = count;
    rec.ovf    = ovf;
    rec.perr   = perr;
    rec.nBytes = nBytes;
    expQ.push_back(rec);
  endtask

  task automatic pushByte(input int addr, input logic [7:0] data);
    expAddrQ.push_back(addr);
    expDataQ.push_back(data);
  endtask

  task automatic applyStimulus(input bit skip);
    @(posedge clk_sys) #1;
    busIf.skip_name = skip;
    busIf.arm       = 1'b1;
    @(posedge clk_sys) #1;
    busIf.arm       = 1'b0;
  endtask

  // 80 ns pulse period; g adds a double edge on the first pulse and short dips on the rest.
  task automatic pulses(input int n, input bit g);
    for (int i = 0; i < n; i++) begin
      busIf.mic = 1'b1;
      if (g && i == 0) begin
        #10 busIf.mic = 1'b0;
        #10 busIf.mic = 1'b1;
        #20;
      end else if (g) begin
        #12 busIf.mic = 1'b0;
        #5  busIf.mic = 1'b1;
        #23;
      end else begin
        #40;
      end
      busIf.mic = 1'b0;
      #40;
    end
  endtask

  task automatic sendBit(input int n, input bit g);
    pulses(n, g);
    repeat (24) @(posedge clk_sys);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit g);
    for (int i = 7; i >= 0; i--) begin
      sendBit(b[i] ? 9 : 4, g);
    end
  endtask

  task automatic endRecording();
    int waited;
    repeat (260) @(posedge clk_sys);
    waited = 0;
    while (busIf.done !== 1'b1 && waited < 300) begin
      @(negedge clk_sys);
      waited++;
    end
    checkOutput("done_seen", busIf.done, 1);
    repeat (40) @(posedge clk_sys);
    #1;
  endtask

  // Monitor: on each rising done, pop the expected record and read the buffer back.
  initial begin : monitor
    bit   prevDone;
    exp_t rec;
    int   a;
    logic [7:0] d;
    prevDone      = 1'b0;
    busIf.rd_addr = '0;
    forever begin
      @(negedge clk_sys);
      if (busIf.done === 1'b1 && !prevDone) begin
        checkOutput("exp_pending", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          rec = expQ.pop_front();
          checkOutput("byte_count", 32'(busIf.byte_count), rec.count);
          checkOutput("overflow", busIf.overflow, rec.ovf);
          checkOutput("pulse_err", busIf.pulse_err, rec.perr);
          checkOutput("busy_at_done", busIf.busy, 0);
          for (int k = 0; k < rec.nBytes; k++) begin
            a = expAddrQ.pop_front();
            d = expDataQ.pop_front();
            busIf.rd_addr = AW'(a);
            @(negedge clk_sys);
            checkOutput($sformatf("buf[%0d]", a), busIf.rd_data, d);
          end
        end
      end
      prevDone = (busIf.done === 1'b1);
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    busIf.ce_tick   = 1'b1;
    busIf.arm       = 1'b0;
    busIf.skip_name = 1'b0;
    busIf.mic       = 1'b0;
    reset           = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("rst_count", 32'(busIf.byte_count), 0);
    checkOutput("rst_busy", busIf.busy, 0);
    checkOutput("rst_done", busIf.done, 0);
    checkOutput("rst_overflow", busIf.overflow, 0);
    checkOutput("rst_pulse_err", busIf.pulse_err, 0);
    checkOutput("rst_rd_data", busIf.rd_data, 0);
    reset = 1'b0;

    // Plain .o capture of one byte.
    pushExp(1, 0, 0, 1);
    pushByte(0, 8'hA3);
    applyStimulus(0);
    checkOutput("armed_busy", busIf.busy, 1);
    sendByte(8'hA3, 0);
    endRecording();

    // .p capture: name bytes discarded up to the bit7 terminator.
    pushExp(2, 0, 0, 2);
    pushByte(0, 8'h00);
    pushByte(1, 8'h7F);
    applyStimulus(1);
    sendByte(8'h26, 0);
    sendByte(8'hB1, 0);
    checkOutput("name_discard", 32'(busIf.byte_count), 0);
    sendByte(8'h00, 0);
    sendByte(8'h7F, 0);
    endRecording();

    // Glitches and double edges must not change the decode.
    pushExp(2, 0, 0, 2);
    pushByte(0, 8'hA3);
    pushByte(1, 8'h5C);
    applyStimulus(0);
    sendByte(8'hA3, 1);
    sendByte(8'h5C, 1);
    endRecording();

    // Fill the 16-byte buffer, then one more byte overflows.
    pushExp(16, 1, 0, 2);
    pushByte(0, 8'h55);
    pushByte(15, 8'h55);
    applyStimulus(0);
    for (int i = 0; i < 16; i++) sendByte(8'h55, 0);
    checkOutput("full_count", 32'(busIf.byte_count), 16);
    checkOutput("full_no_ovf", busIf.overflow, 0);
    sendByte(8'h55, 0);
    endRecording();

    // Arm from DONE clears sticky flags; a 20-pulse bit flags pulse_err and reads as 1.
    applyStimulus(0);
    checkOutput("rearm_done", busIf.done, 0);
    checkOutput("rearm_overflow", busIf.overflow, 0);
    checkOutput("rearm_count", 32'(busIf.byte_count), 0);
    pushExp(1, 0, 1, 1);
    pushByte(0, 8'h81);
    sendBit(20, 0);
    for (int i = 0; i < 6; i++) sendBit(4, 0);
    sendBit(9, 0);
    endRecording();

    // Reset during the third bit, then a clean capture with no stale bits.
    applyStimulus(0);
    checkOutput("rearm_pulse_err", busIf.pulse_err, 0);
    sendBit(9, 0);
    sendBit(4, 0);
    pulses(5, 0);
    @(posedge clk_sys) #1;
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    checkOutput("midrst_count", 32'(busIf.byte_count), 0);
    checkOutput("midrst_busy", busIf.busy, 0);
    checkOutput("midrst_done", busIf.done, 0);
    pushExp(1, 0, 0, 1);
    pushByte(0, 8'h42);
    applyStimulus(0);
    sendByte(8'h42, 0);
    endRecording();

    repeat (20) @(posedge clk_sys);
    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
